aux_int_collector: RTL and testbench

- Input-side counterpart to the board's display/output path.
- Takes raw push-button interrupt lines (int0..int2 on the board) and conditions them: synchronise, debounce, rising-edge detect.
- Latches each edge as a pending interrupt request and presents the highest-priority one to the core over a req/ack handshake.
- Sits in the top level between the board pins and the core's interrupt inputs, clocked by the selected core clock.

---
 rtl/aux_int_collector_pkg.sv | 15 +
 rtl/aux_debouncer.sv | 48 ++++
 rtl/aux_int_collector.sv | 90 +++++++++
 tb/tb_aux_int_collector.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/aux_int_collector_pkg.sv
// Shared defaults and helpers for the push-button interrupt collector.
// Pure declarations: no latency, no flow control.
package aux_int_collector_pkg;

  localparam int AUX_INT_NUM_SRC  = 3;
  localparam int AUX_INT_ID_BIT   = 2;
  localparam int AUX_INT_DEBOUNCE = 4;
  localparam int AUX_INT_LOST_BIT = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aux_debouncer.sv
// One button: 2-flop sync, stability counter, debounced level, registered rise pulse.
// Latency 3+DebounceCnt edges from first sample to rise pulse; no backpressure.
module aux_debouncer
  import aux_int_collector_pkg::*;
#(
  parameter int DebounceCnt = AUX_INT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CntW = cnt_bits(DebounceCnt);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCnt - 1);

  logic            sync_q1;
  logic            sync_q2;
  logic            lvl_q;
  logic            lvl_d1;
  logic [CntW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      lvl_q   <= 1'b0;
      lvl_d1  <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      lvl_d1  <= lvl_q;
      rise    <= lvl_q & ~lvl_d1;
      // Level only follows the synced input after DebounceCnt disagreeing cycles in a row.
      if (sync_q2 == lvl_q) begin
        cnt <= '0;
      end else if (cnt == CntMax) begin
        lvl_q <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/aux_int_collector.sv
// Conditions button lines into pending interrupts, presents lowest pending id over req/ack; AUX_INT_MASK_EN adds int_mask.
// int_req/int_id combinational from pending; ack clears one source per cycle, edges on a pending source are counted as lost.
module aux_int_collector
  import aux_int_collector_pkg::*;
#(
  parameter int NumSrc      = AUX_INT_NUM_SRC,
  parameter int IdBit       = AUX_INT_ID_BIT,
  parameter int DebounceCnt = AUX_INT_DEBOUNCE,
  parameter int LostBit     = AUX_INT_LOST_BIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NumSrc-1:0]  btn,
  input  logic               int_ack,
  input  logic [IdBit-1:0]   int_ack_id,
`ifdef AUX_INT_MASK_EN
  input  logic [NumSrc-1:0]  int_mask,
`endif
  output logic               int_req,
  output logic [IdBit-1:0]   int_id,
  output logic [NumSrc-1:0]  pending,
  output logic [LostBit-1:0] lost_cnt
);

  logic [NumSrc-1:0] rise;
  logic [NumSrc-1:0] ack_hit;
  logic [NumSrc-1:0] lose;
  logic [NumSrc-1:0] pending_nxt;
  logic [NumSrc-1:0] enabled;
  logic [2:0]        lose_sum;
  logic [LostBit:0]  lost_sum;

  for (genvar g = 0; g < NumSrc; g++) begin : g_src
    aux_debouncer #(
      .DebounceCnt(DebounceCnt)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[g]),
      .rise (rise[g])
    );
  end

  // A new edge on a source being acked in the same cycle replaces the old request, so it is not a loss.
  always_comb begin
    ack_hit  = '0;
    lose_sum = '0;
    for (int i = 0; i < NumSrc; i++) begin
      ack_hit[i] = int_ack && (int_ack_id == IdBit'(i));
    end
    lose        = rise & pending & ~ack_hit;
    pending_nxt = rise | (pending & ~ack_hit);
    for (int i = 0; i < NumSrc; i++) begin
      lose_sum = lose_sum + 3'(lose[i]);
    end
    lost_sum = {1'b0, lost_cnt} + (LostBit+1)'(lose_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      lost_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      if (lost_sum[LostBit]) begin
        lost_cnt <= '1;
      end else begin
        lost_cnt <= lost_sum[LostBit-1:0];
      end
    end
  end

`ifdef AUX_INT_MASK_EN
  assign enabled = pending & ~int_mask;
`else
  assign enabled = pending;
`endif

  assign int_req = |enabled;

  always_comb begin
    int_id = '0;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (enabled[i]) begin
        int_id = IdBit'(i);
      end
    end
  end

endmodule

// File: tb/tb_aux_int_collector.sv
// Directed bench for aux_int_collector with hand-computed expectations.
// LostBit is narrowed to 4 so saturation is reachable in a short run.
module tb_aux_int_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic       int_ack;
  logic [1:0] int_ack_id;
`ifdef AUX_INT_MASK_EN
  logic [2:0] int_mask;
`endif
  logic       int_req;
  logic [1:0] int_id;
  logic [2:0] pending;
  logic [3:0] lost_cnt;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aux_int_collector #(
    .NumSrc      (3),
    .IdBit       (2),
    .DebounceCnt (4),
    .LostBit     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .int_ack    (int_ack),
    .int_ack_id (int_ack_id),
`ifdef AUX_INT_MASK_EN
    .int_mask   (int_mask),
`endif
    .int_req    (int_req),
    .int_id     (int_id),
    .pending    (pending),
    .lost_cnt   (lost_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack(input logic [1:0] id);
    int_ack    = 1'b1;
    int_ack_id = id;
    tick(1);
    int_ack    = 1'b0;
    int_ack_id = 2'd0;
  endtask

  task automatic toggle_all();
    btn = 3'b000;
    tick(8);
    btn = 3'b111;
    tick(8);
  endtask

  initial begin
    rst        = 1'b1;
    btn        = 3'b000;
    int_ack    = 1'b0;
    int_ack_id = 2'd0;
`ifdef AUX_INT_MASK_EN
    int_mask   = 3'b000;
`endif
    tick(2);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_lost", 32'(lost_cnt), 32'h0);
    chk("rst_req", 32'(int_req), 32'h0);
    chk("rst_id", 32'(int_id), 32'h0);

    // Source 0 held from edge 0: pending appears after edge 7, not before.
    rst = 1'b0;
    btn = 3'b001;
    tick(7);
    chk("lat_early_pending", 32'(pending), 32'h0);
    chk("lat_early_req", 32'(int_req), 32'h0);
    tick(1);
    chk("lat_pending", 32'(pending), 32'h1);
    chk("lat_req", 32'(int_req), 32'h1);
    chk("lat_id", 32'(int_id), 32'h0);

    // Three-cycle glitch on source 1 never registers.
    btn = 3'b011;
    tick(3);
    btn = 3'b001;
    tick(20);
    chk("glitch_pending", 32'(pending), 32'h1);
    chk("glitch_lost", 32'(lost_cnt), 32'h0);

    ack(2'd0);
    chk("ack0_pending", 32'(pending), 32'h0);
    chk("ack0_req", 32'(int_req), 32'h0);

    // Sources 1 and 2 together; source 0 stays held so no new edge there.
    btn = 3'b111;
    tick(8);
    chk("p110_pending", 32'(pending), 32'h6);
    chk("p110_id", 32'(int_id), 32'h1);
    chk("p110_req", 32'(int_req), 32'h1);
    ack(2'd1);
    chk("ack1_pending", 32'(pending), 32'h4);
    chk("ack1_id", 32'(int_id), 32'h2);
    ack(2'd2);
    chk("ack2_req", 32'(int_req), 32'h0);
    chk("ack2_pending", 32'(pending), 32'h0);
    ack(2'd0);
    chk("ack_idle_pending", 32'(pending), 32'h0);
    chk("ack_idle_id", 32'(int_id), 32'h0);
    chk("ack_idle_lost", 32'(lost_cnt), 32'h0);

    // Re-arm source 2, then out-of-range ack must be ignored.
    btn = 3'b011;
    tick(8);
    btn = 3'b111;
    tick(8);
    chk("src2_pending", 32'(pending), 32'h4);
    ack(2'd3);
    chk("ack_oor_pending", 32'(pending), 32'h4);

    // Second edge on pending source 2 without ack: counted as lost.
    btn = 3'b011;
    tick(8);
    btn = 3'b111;
    tick(8);
    chk("lose1_lost", 32'(lost_cnt), 32'h1);
    chk("lose1_pending", 32'(pending), 32'h4);

    // Edge coincident with ack of source 2 at edge 7: request kept, no loss.
    btn = 3'b011;
    tick(8);
    btn = 3'b111;
    tick(7);
    chk("coinc_pre_pending", 32'(pending), 32'h4);
    int_ack    = 1'b1;
    int_ack_id = 2'd2;
    tick(1);
    int_ack    = 1'b0;
    int_ack_id = 2'd0;
    chk("coinc_pending", 32'(pending), 32'h4);
    chk("coinc_lost", 32'(lost_cnt), 32'h1);

    // Sources 0,1 newly set, source 2 loses: 1 -> 2. Then +3 per toggle.
    toggle_all();
    chk("sat_step_lost", 32'(lost_cnt), 32'h2);
    chk("sat_step_pending", 32'(pending), 32'h7);
    repeat (4) toggle_all();
    chk("multi_lost", 32'(lost_cnt), 32'hE);
    toggle_all();
    chk("sat_lost", 32'(lost_cnt), 32'hF);
    toggle_all();
    chk("sat_hold_lost", 32'(lost_cnt), 32'hF);

    // One-cycle reset with everything pending and source 0 held.
    btn = 3'b001;
    rst = 1'b1;
    tick(1);
    chk("rst2_pending", 32'(pending), 32'h0);
    chk("rst2_lost", 32'(lost_cnt), 32'h0);
    chk("rst2_req", 32'(int_req), 32'h0);
    chk("rst2_id", 32'(int_id), 32'h0);
    rst = 1'b0;
    tick(7);
    chk("rst2_early_pending", 32'(pending), 32'h0);
    tick(1);
    chk("rst2_new_pending", 32'(pending), 32'h1);
    chk("rst2_new_req", 32'(int_req), 32'h1);
    chk("rst2_new_lost", 32'(lost_cnt), 32'h0);

`ifdef AUX_INT_MASK_EN
    int_mask = 3'b001;
    btn      = 3'b011;
    tick(8);
    chk("mask_pending", 32'(pending), 32'h3);
    chk("mask_id", 32'(int_id), 32'h1);
    int_mask = 3'b000;
    #1;
    chk("unmask_id", 32'(int_id), 32'h0);
    chk("unmask_req", 32'(int_req), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
